armleocpu_bus_arbiter: RTL and testbench



---
 rtl/armleocpu_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_armleocpu_bus_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_bus_arbiter.sv
// armleocpu_bus_arbiter: merges CHANNELS cache-side master ports onto one
// downstream memory port. The grant is held for a whole burst. Selection is
// round-robin (PRIORITY_MODE 0) or fixed lowest-index priority (PRIORITY_MODE 1).
module armleocpu_bus_arbiter #(
   parameter int CHANNELS      = 2,
   parameter int ADDR_W        = 34,
   parameter int DATA_W        = 32,
   parameter int BURST_W       = 4,
   parameter int PRIORITY_MODE = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,

   input  logic [CHANNELS-1:0]             s_transaction,
   input  logic [CHANNELS*3-1:0]           s_cmd,
   input  logic [CHANNELS*ADDR_W-1:0]      s_address,
   input  logic [CHANNELS*BURST_W-1:0]     s_burstcount,
   input  logic [CHANNELS*DATA_W-1:0]      s_wdata,
   input  logic [CHANNELS*(DATA_W/8)-1:0]  s_wbyte_enable,
   output logic [CHANNELS-1:0]             s_transaction_done,
   output logic [CHANNELS*3-1:0]           s_transaction_response,
   output logic [CHANNELS*DATA_W-1:0]      s_rdata,

   output logic                            m_transaction,
   output logic [2:0]                      m_cmd,
   output logic [ADDR_W-1:0]               m_address,
   output logic [BURST_W-1:0]              m_burstcount,
   output logic [DATA_W-1:0]               m_wdata,
   output logic [DATA_W/8-1:0]             m_wbyte_enable,
   input  logic                            m_transaction_done,
   input  logic [2:0]                      m_transaction_response,
   input  logic [DATA_W-1:0]               m_rdata,

   output logic [CHANNELS-1:0]             grant,
   output logic                            busy
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t               state, state_nxt;
   logic [CHANNELS-1:0]  grant_nxt;
   logic [BURST_W-1:0]   beat_cnt, beat_cnt_nxt;
   logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;

   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W-1:0]     gnt_idx;
   logic [BURST_W-1:0]   beats_m1;
   logic                 last_beat;

   // read data goes to every channel; only the granted one sees done
   assign s_rdata = {CHANNELS{m_rdata}};
   assign busy    = (state == ACTIVE);

   // winner search: from rr_ptr upward with wrap, or from index 0 in fixed mode
   always_comb begin
      int unsigned cand;
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (PRIORITY_MODE == 1)
            cand = k;
         else
            cand = (int'(rr_ptr) + k) % CHANNELS;
         if (!win_found && s_transaction[IDX_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   // one-hot grant to index
   always_comb begin
      gnt_idx = '0;
      for (int unsigned k = 0; k < CHANNELS; k++)
         if (grant[k]) gnt_idx = IDX_W'(k);
   end

   // downstream mux and upstream done/response routing, all zero when idle
   always_comb begin
      m_transaction          = 1'b0;
      m_cmd                  = '0;
      m_address              = '0;
      m_burstcount           = '0;
      m_wdata                = '0;
      m_wbyte_enable         = '0;
      s_transaction_done     = '0;
      s_transaction_response = '0;
      if (state == ACTIVE) begin
         m_transaction  = 1'b1;
         m_cmd          = s_cmd[gnt_idx*3 +: 3];
         m_address      = s_address[gnt_idx*ADDR_W +: ADDR_W];
         m_burstcount   = s_burstcount[gnt_idx*BURST_W +: BURST_W];
         m_wdata        = s_wdata[gnt_idx*DATA_W +: DATA_W];
         m_wbyte_enable = s_wbyte_enable[gnt_idx*BE_W +: BE_W];
         s_transaction_done[gnt_idx]           = m_transaction_done;
         s_transaction_response[gnt_idx*3 +: 3] = m_transaction_response;
      end
   end

   // final-beat detection; burstcount 0 behaves as a single beat
   always_comb begin
      beats_m1  = (m_burstcount == '0) ? '0 : m_burstcount - 1'b1;
      last_beat = m_transaction_done &&
                  ((beat_cnt == beats_m1) || (m_transaction_response != 3'd0));
   end

   // next-state logic for IDLE/ACTIVE, grant, beat counter and rr pointer
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      beat_cnt_nxt = beat_cnt;
      rr_ptr_nxt   = rr_ptr;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt          = ACTIVE;
               grant_nxt          = '0;
               grant_nxt[win_idx] = 1'b1;
               beat_cnt_nxt       = '0;
               if (PRIORITY_MODE == 0)
                  rr_ptr_nxt = IDX_W'((int'(win_idx) + 1) % CHANNELS);
            end
         end
         ACTIVE: begin
            if (m_transaction_done)
               beat_cnt_nxt = beat_cnt + 1'b1;
            if (last_beat) begin
               state_nxt    = IDLE;
               grant_nxt    = '0;
               beat_cnt_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= '0;
         beat_cnt <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         beat_cnt <= beat_cnt_nxt;
         rr_ptr   <= rr_ptr_nxt;
      end
   end

endmodule

// File: tb/tb_armleocpu_bus_arbiter.sv
// Directed bench: a round-robin 2-channel instance and a fixed-priority
// 3-channel instance, each driven by hand-written vectors.
module tb_armleocpu_bus_arbiter;

   localparam int AW = 34;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int EW = DW / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // round-robin instance, 2 channels
   logic [1:0]      rr_req = '0;
   logic [5:0]      rr_cmd = '0;
   logic [2*AW-1:0] rr_addr = '0;
   logic [2*BW-1:0] rr_bc = '0;
   logic [2*DW-1:0] rr_wdata = '0;
   logic [2*EW-1:0] rr_be = '0;
   logic [1:0]      rr_done;
   logic [5:0]      rr_resp;
   logic [2*DW-1:0] rr_rdata;
   logic            rr_mtrans;
   logic [2:0]      rr_mcmd;
   logic [AW-1:0]   rr_maddr;
   logic [BW-1:0]   rr_mbc;
   logic [DW-1:0]   rr_mwdata;
   logic [EW-1:0]   rr_mbe;
   logic            rr_mdone = 1'b0;
   logic [2:0]      rr_mresp = '0;
   logic [1:0]      rr_grant;
   logic            rr_busy;

   // fixed-priority instance, 3 channels
   logic [2:0]      fp_req = '0;
   logic [8:0]      fp_cmd = '0;
   logic [3*AW-1:0] fp_addr = '0;
   logic [3*BW-1:0] fp_bc = '0;
   logic [3*DW-1:0] fp_wdata = '0;
   logic [3*EW-1:0] fp_be = '0;
   logic [2:0]      fp_done;
   logic [8:0]      fp_resp;
   logic [3*DW-1:0] fp_rdata;
   logic            fp_mtrans;
   logic [2:0]      fp_mcmd;
   logic [AW-1:0]   fp_maddr;
   logic [BW-1:0]   fp_mbc;
   logic [DW-1:0]   fp_mwdata;
   logic [EW-1:0]   fp_mbe;
   logic            fp_mdone = 1'b0;
   logic [2:0]      fp_mresp = '0;
   logic [2:0]      fp_grant;
   logic            fp_busy;

   logic [DW-1:0]   m_rdata = 32'hCAFE_F00D;

   armleocpu_bus_arbiter #(
      .CHANNELS(2), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .PRIORITY_MODE(0)
   ) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .s_transaction(rr_req), .s_cmd(rr_cmd), .s_address(rr_addr),
      .s_burstcount(rr_bc), .s_wdata(rr_wdata), .s_wbyte_enable(rr_be),
      .s_transaction_done(rr_done), .s_transaction_response(rr_resp),
      .s_rdata(rr_rdata),
      .m_transaction(rr_mtrans), .m_cmd(rr_mcmd), .m_address(rr_maddr),
      .m_burstcount(rr_mbc), .m_wdata(rr_mwdata), .m_wbyte_enable(rr_mbe),
      .m_transaction_done(rr_mdone), .m_transaction_response(rr_mresp),
      .m_rdata(m_rdata),
      .grant(rr_grant), .busy(rr_busy)
   );

   armleocpu_bus_arbiter #(
      .CHANNELS(3), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .PRIORITY_MODE(1)
   ) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .s_transaction(fp_req), .s_cmd(fp_cmd), .s_address(fp_addr),
      .s_burstcount(fp_bc), .s_wdata(fp_wdata), .s_wbyte_enable(fp_be),
      .s_transaction_done(fp_done), .s_transaction_response(fp_resp),
      .s_rdata(fp_rdata),
      .m_transaction(fp_mtrans), .m_cmd(fp_mcmd), .m_address(fp_maddr),
      .m_burstcount(fp_mbc), .m_wdata(fp_mwdata), .m_wbyte_enable(fp_mbe),
      .m_transaction_done(fp_mdone), .m_transaction_response(fp_mresp),
      .m_rdata(m_rdata),
      .grant(fp_grant), .busy(fp_busy)
   );

   // advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      rr_req = 2'b01;
      fp_req = 3'b111;
      tick();
      tick();
      checks++;
      if (rr_grant !== 2'b00 || rr_busy !== 1'b0 || rr_mtrans !== 1'b0) begin
         errors++;
         $display("FAIL reset_rr: grant=%b busy=%b mtrans=%b required 00 0 0", rr_grant, rr_busy, rr_mtrans);
      end
      checks++;
      if (fp_grant !== 3'b000 || fp_busy !== 1'b0 || fp_maddr !== '0 || fp_done !== 3'b000) begin
         errors++;
         $display("FAIL reset_fp: grant=%b busy=%b maddr=%h done=%b required 000 0 0 000", fp_grant, fp_busy, fp_maddr, fp_done);
      end
      rr_req = 2'b00;
      fp_req = 3'b000;
      rst_n  = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      rr_addr[AW-1:0] = 34'h100;
      rr_bc[BW-1:0]   = 4'd1;
      rr_req = 2'b01;
      #1;
      checks++;
      if (rr_mtrans !== 1'b0) begin
         errors++;
         $display("FAIL single_latency0: mtrans=%b required 0", rr_mtrans);
      end
      tick();
      checks++;
      if (rr_mtrans !== 1'b1 || rr_grant !== 2'b01 || rr_maddr !== 34'h100 || rr_busy !== 1'b1) begin
         errors++;
         $display("FAIL single_start: mtrans=%b grant=%b addr=%h busy=%b required 1 01 100 1", rr_mtrans, rr_grant, rr_maddr, rr_busy);
      end
      rr_mdone = 1'b1;
      rr_mresp = 3'd0;
      #1;
      checks++;
      if (rr_done !== 2'b01 || rr_resp !== 6'd0 || rr_rdata !== {2{32'hCAFE_F00D}}) begin
         errors++;
         $display("FAIL single_done: done=%b resp=%h rdata=%h required 01 00 cafef00dcafef00d", rr_done, rr_resp, rr_rdata);
      end
      tick();
      rr_mdone = 1'b0;
      rr_req   = 2'b00;
      checks++;
      if (rr_grant !== 2'b00 || rr_mtrans !== 1'b0 || rr_busy !== 1'b0) begin
         errors++;
         $display("FAIL single_end: grant=%b mtrans=%b busy=%b required 00 0 0", rr_grant, rr_mtrans, rr_busy);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      // restart from pointer 0 so ch0 wins first
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      rr_addr = {34'h2_0000_0200, 34'h100};
      rr_cmd  = {3'd1, 3'd0};
      rr_bc   = {4'd1, 4'd1};
      rr_req  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (rr_grant !== exp_g[i] || rr_maddr !== (exp_g[i][1] ? 34'h2_0000_0200 : 34'h100) ||
             rr_mcmd !== (exp_g[i][1] ? 3'd1 : 3'd0)) begin
            errors++;
            $display("FAIL rr_grant%0d: grant=%b addr=%h cmd=%0d required %b", i, rr_grant, rr_maddr, rr_mcmd, exp_g[i]);
         end
         rr_mdone = 1'b1;
         #1;
         checks++;
         if (rr_done !== exp_g[i]) begin
            errors++;
            $display("FAIL rr_done%0d: done=%b required %b", i, rr_done, exp_g[i]);
         end
         tick();
         rr_mdone = 1'b0;
         checks++;
         if (rr_grant !== 2'b00 || rr_busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_gap%0d: grant=%b busy=%b required 00 0", i, rr_grant, rr_busy);
         end
      end
      rr_req = 2'b00;
      tick();
   endtask

   task automatic test_burst_lock();
      rr_bc  = {4'd1, 4'd4};
      rr_req = 2'b01;
      tick();
      checks++;
      if (rr_grant !== 2'b01 || rr_mbc !== 4'd4) begin
         errors++;
         $display("FAIL burst_start: grant=%b bc=%0d required 01 4", rr_grant, rr_mbc);
      end
      for (int b = 0; b < 4; b++) begin
         tick();
         checks++;
         if (rr_grant !== 2'b01 || rr_busy !== 1'b1) begin
            errors++;
            $display("FAIL burst_hold%0d: grant=%b busy=%b required 01 1", b, rr_grant, rr_busy);
         end
         rr_mdone = 1'b1;
         #1;
         checks++;
         if (rr_done !== 2'b01) begin
            errors++;
            $display("FAIL burst_done%0d: done=%b required 01", b, rr_done);
         end
         tick();
         rr_mdone = 1'b0;
         if (b == 0) rr_req = 2'b11;
      end
      rr_req = 2'b10;
      checks++;
      if (rr_grant !== 2'b00 || rr_busy !== 1'b0) begin
         errors++;
         $display("FAIL burst_idle: grant=%b busy=%b required 00 0", rr_grant, rr_busy);
      end
      tick();
      checks++;
      if (rr_grant !== 2'b10 || rr_mbc !== 4'd1) begin
         errors++;
         $display("FAIL burst_next: grant=%b bc=%0d required 10 1", rr_grant, rr_mbc);
      end
      rr_mdone = 1'b1;
      tick();
      rr_mdone = 1'b0;
      rr_req   = 2'b00;
      tick();
   endtask

   task automatic test_error_term();
      rr_bc  = {4'd1, 4'd4};
      rr_req = 2'b01;
      tick();
      rr_mdone = 1'b1;
      rr_mresp = 3'd0;
      tick();
      rr_mresp = 3'd2;
      #1;
      checks++;
      if (rr_done !== 2'b01 || rr_resp[2:0] !== 3'd2 || rr_resp[5:3] !== 3'd0) begin
         errors++;
         $display("FAIL err_resp: done=%b resp=%h required 01 02", rr_done, rr_resp);
      end
      tick();
      rr_mdone = 1'b0;
      rr_mresp = 3'd0;
      rr_req   = 2'b00;
      checks++;
      if (rr_busy !== 1'b0 || rr_grant !== 2'b00 || rr_mtrans !== 1'b0) begin
         errors++;
         $display("FAIL err_end: busy=%b grant=%b mtrans=%b required 0 00 0", rr_busy, rr_grant, rr_mtrans);
      end
      tick();
   endtask

   task automatic test_zero_burst();
      rr_bc  = {4'd1, 4'd0};
      rr_req = 2'b01;
      tick();
      rr_mdone = 1'b1;
      tick();
      rr_mdone = 1'b0;
      rr_req   = 2'b00;
      checks++;
      if (rr_busy !== 1'b0 || rr_grant !== 2'b00) begin
         errors++;
         $display("FAIL zero_burst: busy=%b grant=%b required 0 00", rr_busy, rr_grant);
      end
      tick();
   endtask

   task automatic test_reset_midburst();
      // pointer is 1 here; ch0 wins and leaves it at 1 again
      rr_bc  = {4'd1, 4'd4};
      rr_req = 2'b01;
      tick();
      rr_mdone = 1'b1;
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (rr_done !== 2'b01) begin
         errors++;
         $display("FAIL mid_done_before: done=%b required 01", rr_done);
      end
      tick();
      checks++;
      if (rr_mtrans !== 1'b0 || rr_grant !== 2'b00 || rr_done !== 2'b00 || rr_busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: mtrans=%b grant=%b done=%b busy=%b required 0 00 00 0", rr_mtrans, rr_grant, rr_done, rr_busy);
      end
      rst_n    = 1'b1;
      rr_mdone = 1'b0;
      rr_req   = 2'b00;
      tick();
      rr_bc  = {4'd1, 4'd1};
      rr_req = 2'b11;
      tick();
      checks++;
      if (rr_grant !== 2'b01) begin
         errors++;
         $display("FAIL mid_ptr0: grant=%b required 01", rr_grant);
      end
      rr_mdone = 1'b1;
      tick();
      rr_mdone = 1'b0;
      rr_req   = 2'b10;
      tick();
      checks++;
      if (rr_grant !== 2'b10) begin
         errors++;
         $display("FAIL mid_ch1: grant=%b required 10", rr_grant);
      end
      rr_mdone = 1'b1;
      tick();
      rr_mdone = 1'b0;
      rr_req   = 2'b00;
      tick();
   endtask

   task automatic test_fixed_priority();
      logic [2:0] reqs  [5];
      logic [2:0] exp_g [5];
      reqs[0] = 3'b111; exp_g[0] = 3'b001;
      reqs[1] = 3'b111; exp_g[1] = 3'b001;
      reqs[2] = 3'b111; exp_g[2] = 3'b001;
      reqs[3] = 3'b110; exp_g[3] = 3'b010;
      reqs[4] = 3'b100; exp_g[4] = 3'b100;
      fp_bc    = {4'd1, 4'd1, 4'd1};
      fp_cmd   = {3'd5, 3'd3, 3'd1};
      fp_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      fp_be    = {4'hC, 4'h3, 4'hF};
      fp_addr  = {34'h300, 34'h200, 34'h100};
      for (int i = 0; i < 5; i++) begin
         fp_req = reqs[i];
         tick();
         checks++;
         if (fp_grant !== exp_g[i] || fp_mbc !== 4'd1) begin
            errors++;
            $display("FAIL fp_grant%0d: grant=%b bc=%0d required %b 1", i, fp_grant, fp_mbc, exp_g[i]);
         end
         fp_mdone = 1'b1;
         fp_mresp = 3'd1;
         #1;
         checks++;
         if (fp_done !== exp_g[i] || fp_rdata !== {3{32'hCAFE_F00D}}) begin
            errors++;
            $display("FAIL fp_done%0d: done=%b rdata=%h required %b", i, fp_done, fp_rdata, exp_g[i]);
         end
         if (i == 4) begin
            checks++;
            if (fp_mcmd !== 3'd5 || fp_mwdata !== 32'h3333_3333 || fp_mbe !== 4'hC ||
                fp_maddr !== 34'h300 || fp_resp !== 9'b001_000_000 || fp_mtrans !== 1'b1) begin
               errors++;
               $display("FAIL fp_mux_ch2: cmd=%0d wdata=%h be=%h addr=%h resp=%b required 5 33333333 c 300 001000000",
                        fp_mcmd, fp_mwdata, fp_mbe, fp_maddr, fp_resp);
            end
         end
         tick();
         fp_mdone = 1'b0;
         fp_mresp = 3'd0;
      end
      fp_req = 3'b000;
      tick();
      checks++;
      if (fp_busy !== 1'b0 || fp_grant !== 3'b000) begin
         errors++;
         $display("FAIL fp_idle: busy=%b grant=%b required 0 000", fp_busy, fp_grant);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_burst_lock();
      test_error_term();
      test_zero_burst();
      test_reset_midburst();
      test_fixed_priority();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
